mnist_frame_rx: RTL
===================

# mnist_frame_rx

Byte-stream frame assembler that sits directly downstream of `uart_rx` and upstream of the classifier's image buffer. It parses one frame: a label byte, then 28x28 pixels of 4 little-endian bytes each, row-major. It emits one 32-bit pixel write per completed word and returns a one-byte ACK, or a NAK on timeout, through `uart_tx`. It then holds the frame until the consumer releases it.

## Interface
- `IMG_W`, 28, pixels per row
- `IMG_H`, 28, rows per frame
- `TIMEOUT`, 1_000_000, max idle clocks between bytes inside a frame (20 ms at 50 MHz)
- `ACK_BYTE`, 8'h4B ("K"), sent on good frame
- `NAK_BYTE`, 8'h45 ("E"), sent on timeout
- `sys_clk` in 1 system clock; everything is synchronous to its rising edge
- `rst` in 1 reset, asynchronous, active-low
- `rx_valid` in 1 one-cycle strobe, new byte from `uart_rx`
- `rx_data` in 8 received byte, valid when `rx_valid`=1
- `tx_ready` in 1 `uart_tx` idle and able to accept a byte
- `tx_start` out 1 one-cycle request to send `tx_data`
- `tx_data` out 8 byte to transmit
- `px_we` out 1 one-cycle pixel write strobe
- `px_addr` out 10 pixel index y*IMG_W+x, 0..783
- `px_data` out 32 assembled pixel word
- `label` out 4 label of current frame
- `frame_valid` out 1 complete frame held, level
- `img_release` in 1 one-cycle strobe from consumer, frees the buffer
- `overrun` out 1 sticky; a byte arrived while the buffer was held

## Operation
- States: IDLE, PIXEL, ACK, NAK, FULL.
- **IDLE**
  - On `rx_valid` with `rx_data` in 0..9: latch `label`=`rx_data[3:0]`, clear the byte index, x, y and timeout counter, go to PIXEL.
  - Byte values >9 are discarded; the state stays IDLE.
- **PIXEL**
  - Each `rx_valid` shifts into the word register: `word = {rx_data, word[31:8]}`. Byte 0 ends up in [7:0].
  - The 2-bit byte index increments on every byte.
  - On the 4th byte (index 3): `px_we`=1 next cycle with `px_addr`=y*IMG_W+x and `px_data`=the complete word. Then x advances; at x=IMG_W-1, x wraps to 0 and y increments.
  - The write for pixel (IMG_W-1, IMG_H-1) is the last one. In the same cycle the FSM enters ACK and `tx_data`=ACK_BYTE.
  - The timeout counter clears on every `rx_valid` and increments otherwise. At TIMEOUT the partial frame is abandoned, `tx_data`=NAK_BYTE and the FSM enters NAK. Pixels already written are not retracted.
- **ACK / NAK**
  - Wait for `tx_ready`=1, then pulse `tx_start` for exactly one cycle.
  - ACK then goes to FULL and sets `frame_valid`=1. NAK goes to IDLE.
  - A byte arriving in ACK is dropped and sets `overrun`. A byte arriving in NAK is dropped without setting `overrun`.
- **FULL**
  - Every `rx_valid` is dropped and sets `overrun`.
  - `img_release` clears `frame_valid` and `overrun` and returns to IDLE.
  - `img_release` in any other state is ignored.
- If `img_release` and `rx_valid` coincide in FULL: the release wins, the byte is dropped and `overrun` ends at 0.
- Pixel counters are 5 bits each; x and y never exceed IMG_W-1 / IMG_H-1. Address arithmetic is 10 bits unsigned.

## Timing
- Reset values, effective immediately on `rst`=0 regardless of state: state IDLE; `tx_start`, `px_we`, `frame_valid` and `overrun` all 0; `tx_data`, `px_addr`, `px_data` and `label` all 0; all counters 0.
- `px_we` latency: asserted exactly 1 cycle after the `rx_valid` carrying byte 3. It is high for 1 cycle; `px_addr`/`px_data` hold until the next write.
- `tx_start` is asserted only in a cycle where `tx_ready`=1 was sampled, and never more than once per frame. If `tx_ready` is already 1, the earliest `tx_start` is 1 cycle after entering ACK/NAK.
- `frame_valid` rises on the cycle after the ACK `tx_start` pulse. It falls on the cycle after `img_release`.
- Timeout fires on the cycle where the counter reaches TIMEOUT, i.e. TIMEOUT clocks after the last byte. It is only active in PIXEL.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss.

## Test plan
- **Good frame:** label 0x07, then pixel i sent as bytes {i, 0xA5, 0x00, 0x5A}, for 3136 bytes in total. Require 784 `px_we` pulses with `px_addr`=i and `px_data`=0x5A00A5(i[7:0]), then one `tx_start` with `tx_data`=0x4B, then `frame_valid`=1 and `label`=7.
- **Bad label:** send 0x3F, then label 0x02 and a full frame. Require the 0x3F to be ignored and `label`=2 at the end; the first `px_we` carries word bytes 1..4.
- **Timeout:** label 0x01 and 10 bytes, then silence (TIMEOUT=1000 in bench). Require exactly 2 writes, a NAK `tx_data`=0x45 at 1000 cycles after the last byte, and a return to IDLE with `frame_valid`=0.
- **Overrun/release:** after a good frame, send 3 bytes in FULL. Require `overrun`=1 with no `px_we`. Then `img_release`: require `frame_valid`=0, `overrun`=0, and a new label accepted.
- **tx backpressure:** hold `tx_ready`=0 for 500 cycles after the last pixel. Require no `tx_start` until 1 cycle after `tx_ready` rises, and exactly one pulse.
- **Reset mid-frame:** assert `rst`=0 after pixel 100. Require all outputs 0 asynchronously, then a full new frame that starts at `px_addr`=0.

Source files
------------

// File: rtl/mnist_frame_rx.sv
// Frame assembler between uart_rx and the image buffer: label byte, then 28x28
// little-endian 32-bit pixels. Answers ACK/NAK through uart_tx and holds the frame until released.
module mnist_frame_rx #(
    parameter int         IMG_W    = 28,
    parameter int         IMG_H    = 28,
    parameter int         TIMEOUT  = 1_000_000,
    parameter logic [7:0] ACK_BYTE = 8'h4B,
    parameter logic [7:0] NAK_BYTE = 8'h45
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        px_we,
    output logic [9:0]  px_addr,
    output logic [31:0] px_data,
    output logic [3:0]  label,
    output logic        frame_valid,
    input  logic        img_release,
    output logic        overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PIXEL = 3'd1,
        ST_ACK   = 3'd2,
        ST_NAK   = 3'd3,
        ST_FULL  = 3'd4
    } state_t;

    // Counter only needs to reach TIMEOUT-1; the NAK fires on the following idle clock.
    localparam int          TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]  X_LAST  = 5'(IMG_W - 1);
    localparam logic [4:0]  Y_LAST  = 5'(IMG_H - 1);
    localparam logic [9:0]  W10     = 10'(IMG_W);

    state_t          state_r;
    logic [23:0]     word_r;
    logic [1:0]      byte_idx_r;
    logic [4:0]      x_r;
    logic [4:0]      y_r;
    logic [TW-1:0]   to_cnt_r;

    // Frame parser FSM with all outputs registered.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            word_r      <= 24'd0;
            byte_idx_r  <= 2'd0;
            x_r         <= 5'd0;
            y_r         <= 5'd0;
            to_cnt_r    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            px_we       <= 1'b0;
            px_addr     <= 10'd0;
            px_data     <= 32'd0;
            label       <= 4'd0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            px_we    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid && (rx_data <= 8'd9)) begin
                        label      <= rx_data[3:0];
                        byte_idx_r <= 2'd0;
                        x_r        <= 5'd0;
                        y_r        <= 5'd0;
                        to_cnt_r   <= '0;
                        state_r    <= ST_PIXEL;
                    end
                end
                ST_PIXEL: begin
                    if (rx_valid) begin
                        to_cnt_r   <= '0;
                        word_r     <= {rx_data, word_r[23:8]};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            px_we   <= 1'b1;
                            px_addr <= 10'(y_r) * W10 + 10'(x_r);
                            px_data <= {rx_data, word_r};
                            if (x_r == X_LAST) begin
                                x_r <= 5'd0;
                                if (y_r == Y_LAST) begin
                                    y_r     <= 5'd0;
                                    tx_data <= ACK_BYTE;
                                    state_r <= ST_ACK;
                                end else begin
                                    y_r <= y_r + 5'd1;
                                end
                            end else begin
                                x_r <= x_r + 5'd1;
                            end
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        to_cnt_r <= '0;
                        tx_data  <= NAK_BYTE;
                        state_r  <= ST_NAK;
                    end else begin
                        to_cnt_r <= to_cnt_r + TW'(1);
                    end
                end
                ST_ACK: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        state_r  <= ST_FULL;
                    end
                end
                ST_NAK: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_FULL: begin
                    // Release wins over a coincident byte, so overrun ends cleared.
                    if (img_release) begin
                        frame_valid <= 1'b0;
                        overrun     <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        frame_valid <= 1'b1;
                        if (rx_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
